rns_banked_reg_file: RTL
========================

// Module: rns_banked_reg_file
// PURPOSE
//  Parametrised successor to the processor register file: an integer bank plus an RNS bank of NUM_DOMAINS residues.
//  Adds registered reads, write-to-read bypass and per-domain write masks.
//  Adds a destination scoreboard for pipeline hazard detection and a sequenced bulk-clear engine.
//  Sits between decode (read/reserve) and writeback (write) in the RISC-RNS datapath.
// PARAMETERS
//  NUM_DOMAINS  2   residue domains per RNS register (>=1)
//  DOMAIN_W     8   bits per domain; integer bank width
//  DEPTH        8   registers per bank (power of 2, >=2)
//  ADDR_W       1+$clog2(DEPTH)  derived; MSB = bank select (1 = RNS)
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  reset      in   1                    asynchronous, active-high
//  rd_en      in   1                    capture read ports this cycle
//  rd_addr1   in   ADDR_W               read port 1 address
//  rd_addr2   in   ADDR_W               read port 2 address
//  rd_addr3   in   ADDR_W-1             integer-bank-only read (RSTORE/OUTPUT)
//  rd_data1   out  NUM_DOMAINS*DOMAIN_W read data 1
//  rd_data2   out  NUM_DOMAINS*DOMAIN_W read data 2
//  rd_data3   out  DOMAIN_W             read data 3
//  rd_hazard  out  2                    [0]/[1]: port 1/2 read a reserved register
//  wr_en      in   1                    write strobe
//  wr_addr    in   ADDR_W               write address
//  wr_mask    in   NUM_DOMAINS          per-domain write enable (RNS bank); int bank uses bit 0
//  wr_data    in   NUM_DOMAINS*DOMAIN_W write data, domain i at [i*DOMAIN_W +: DOMAIN_W]
//  rsv_en     in   1                    reserve destination (sets busy bit)
//  rsv_addr   in   ADDR_W               destination being reserved
//  clr_req    in   1                    pulse: start bulk clear of both banks
//  clr_busy   out  1                    clear engine active
// BEHAVIOUR
//  Reset (async): all entries, busy bits, rd_data1/2/3, rd_hazard = 0; FSM = IDLE; clr_busy = 0.
//  Reads: 1-cycle latency; registered on the edge where rd_en = 1; outputs hold when rd_en = 0.
//   Int-bank reads are zero-extended to NUM_DOMAINS*DOMAIN_W. rd_hazard is registered alongside the data.
//  Writes: commit on the edge with wr_en = 1.
//   RNS bank: only domains with wr_mask[i] = 1 change.
//   Int bank: wr_data[DOMAIN_W-1:0] is written iff wr_mask[0] = 1.
//  Bypass: if rd_en and wr_en coincide on a matching address, rd_data returns the post-write (mask-merged) value.
//   rd_data3 compares against int-bank writes only.
//  Scoreboard: one busy bit per register, both banks.
//   rsv_en sets the busy bit. A write clears it unless wr_mask == 0.
//   If rsv and write hit the same address in one cycle, the busy bit ends at 1 (new reservation wins).
//   rd_hazard[n] = busy bit of rd_addrN after that cycle's write clear, so bypassed data is not flagged.
//  Clear FSM: IDLE -> CLEAR -> IDLE.
//   clr_req in IDLE enters CLEAR with idx = 0. CLEAR zeroes entry idx in both banks plus its busy bit, one per cycle.
//   After idx = DEPTH-1 the FSM returns to IDLE, DEPTH cycles in total.
//   clr_busy = 1 exactly while in CLEAR. clr_req is ignored during CLEAR.
//   While in CLEAR: wr_en and rsv_en are ignored (the controller must stall); reads return 0 with rd_hazard = 0.
//   Async reset during CLEAR aborts to IDLE with all storage zeroed.
//  Address bits above the bank range are not possible (DEPTH is a power of 2); no wrap handling is required.
// STRUCTURE
//  Shared package rf_pkg: DOMAIN_W/NUM_DOMAINS defaults, BANK_INT/BANK_RNS constants, clr_state_t {IDLE, CLEAR}.
//  Sub-module rf_bank (DEPTH x WIDTH, masked write with LANES lanes, 3 comb read taps, clear-entry port).
//   Instantiated twice: int bank (LANES = 1) and RNS bank (LANES = NUM_DOMAINS).
//  Top level holds the bypass muxes, scoreboard, clear FSM and output registers.
// TESTING
//  1. Reset, then rd_en with addr1 = 4'h9, addr2 = 4'h1, addr3 = 3 -> next cycle all rd_data = 0, rd_hazard = 0.
//  2. Write RNS r2 = 16'hA55A (mask 2'b11), then mask 2'b01 data 16'h00FF, then read 4'hA -> 16'hA5FF.
//  3. Same cycle: wr_en int r5 = 8'h3C and rd_en rd_addr1 = 4'h5, rd_addr3 = 5 -> rd_data1 = 16'h003C, rd_data3 = 8'h3C.
//  4. rsv r4 (4'hC); read 4'hC -> rd_hazard[0] = 1. Write r4 + rsv r4 same cycle -> still busy.
//     Write only -> busy cleared; next read shows rd_hazard = 0.
//  5. Fill all 16 regs, pulse clr_req -> clr_busy high exactly 8 cycles; writes during CLEAR dropped; all reads then 0.
//  6. Assert reset mid-CLEAR (idx = 3) -> clr_busy = 0 immediately, state IDLE, every register reads 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the banked integer/RNS register file.
package rf_pkg;

   localparam int unsigned NUM_DOMAINS_DEF = 2;
   localparam int unsigned DOMAIN_W_DEF    = 8;
   localparam int unsigned DEPTH_DEF       = 8;

   // Bank select value carried in the address MSB
   localparam logic BANK_INT = 1'b0;
   localparam logic BANK_RNS = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage : rf_pkg

// File: rtl/rf_bank.sv
// One storage bank: DEPTH x WIDTH entries, lane-masked write, three
// combinational read taps and a single-entry clear port (clear wins over write).
module rf_bank #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LANES = 2,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [LANES-1:0] wr_mask,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic [AW-1:0]    rd_addr1,
   input  logic [AW-1:0]    rd_addr2,
   input  logic [AW-1:0]    rd_addr3,
   output logic [WIDTH-1:0] rd_data1_c,
   output logic [WIDTH-1:0] rd_data2_c,
   output logic [WIDTH-1:0] rd_data3_c
);

   localparam int unsigned LW = WIDTH / LANES;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage update: async clear of everything, then entry clear, then masked write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_en) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_en) begin
         for (int l = 0; l < LANES; l++) begin
            if (wr_mask[l]) begin
               mem_q[wr_addr][l*LW +: LW] <= wr_data[l*LW +: LW];
            end
         end
      end
   end

   assign rd_data1_c = mem_q[rd_addr1];
   assign rd_data2_c = mem_q[rd_addr2];
   assign rd_data3_c = mem_q[rd_addr3];

endmodule : rf_bank

// File: rtl/rns_banked_reg_file.sv
// Integer + RNS register file with registered reads, write-to-read bypass,
// per-domain write masks, a destination busy scoreboard and a bulk-clear engine.
module rns_banked_reg_file
   import rf_pkg::*;
#(
   parameter int unsigned NUM_DOMAINS = NUM_DOMAINS_DEF,
   parameter int unsigned DOMAIN_W    = DOMAIN_W_DEF,
   parameter int unsigned DEPTH       = DEPTH_DEF,
   parameter int unsigned ADDR_W      = 1 + $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            rd_en,
   input  logic [ADDR_W-1:0]               rd_addr1,
   input  logic [ADDR_W-1:0]               rd_addr2,
   input  logic [ADDR_W-2:0]               rd_addr3,
   output logic [NUM_DOMAINS*DOMAIN_W-1:0] rd_data1,
   output logic [NUM_DOMAINS*DOMAIN_W-1:0] rd_data2,
   output logic [DOMAIN_W-1:0]             rd_data3,
   output logic [1:0]                      rd_hazard,
   input  logic                            wr_en,
   input  logic [ADDR_W-1:0]               wr_addr,
   input  logic [NUM_DOMAINS-1:0]          wr_mask,
   input  logic [NUM_DOMAINS*DOMAIN_W-1:0] wr_data,
   input  logic                            rsv_en,
   input  logic [ADDR_W-1:0]               rsv_addr,
   input  logic                            clr_req,
   output logic                            clr_busy
);

   localparam int unsigned IW   = ADDR_W - 1;
   localparam int unsigned DW   = NUM_DOMAINS * DOMAIN_W;
   localparam int unsigned NREG = 2 * DEPTH;

   clr_state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          in_clear;

   logic wr_go, int_wr, rns_wr;

   logic [DOMAIN_W-1:0] int_rd1_c, int_rd2_c, int_rd3_c;
   logic [DW-1:0]       rns_rd1_c, rns_rd2_c, unused_rns_rd3_c;

   logic [NREG-1:0] busy_q, busy_d, busy_wc;

   logic [DW-1:0]       rd_data1_q, rd_data1_d;
   logic [DW-1:0]       rd_data2_q, rd_data2_d;
   logic [DOMAIN_W-1:0] rd_data3_q, rd_data3_d;
   logic [1:0]          rd_hazard_q, rd_hazard_d;
   logic                clr_busy_q;

   assign in_clear = (state_q == CLEAR);
   assign wr_go    = wr_en && !in_clear;
   assign int_wr   = wr_go && (wr_addr[IW] == BANK_INT) && wr_mask[0];
   assign rns_wr   = wr_go && (wr_addr[IW] == BANK_RNS);

   rf_bank #(
      .DEPTH (DEPTH),
      .WIDTH (DOMAIN_W),
      .LANES (1),
      .AW    (IW)
   ) u_int_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (int_wr),
      .wr_addr    (wr_addr[IW-1:0]),
      .wr_mask    (wr_mask[0]),
      .wr_data    (wr_data[DOMAIN_W-1:0]),
      .clr_en     (in_clear),
      .clr_addr   (idx_q),
      .rd_addr1   (rd_addr1[IW-1:0]),
      .rd_addr2   (rd_addr2[IW-1:0]),
      .rd_addr3   (rd_addr3),
      .rd_data1_c (int_rd1_c),
      .rd_data2_c (int_rd2_c),
      .rd_data3_c (int_rd3_c)
   );

   rf_bank #(
      .DEPTH (DEPTH),
      .WIDTH (DW),
      .LANES (NUM_DOMAINS),
      .AW    (IW)
   ) u_rns_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (rns_wr),
      .wr_addr    (wr_addr[IW-1:0]),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .clr_en     (in_clear),
      .clr_addr   (idx_q),
      .rd_addr1   (rd_addr1[IW-1:0]),
      .rd_addr2   (rd_addr2[IW-1:0]),
      .rd_addr3   ('0),
      .rd_data1_c (rns_rd1_c),
      .rd_data2_c (rns_rd2_c),
      .rd_data3_c (unused_rns_rd3_c)
   );

   // Merge enabled write domains over a stored RNS value (bypass view)
   function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0]          old_v,
                                                 input logic [DW-1:0]          new_v,
                                                 input logic [NUM_DOMAINS-1:0] mask);
      logic [DW-1:0] r;
      r = old_v;
      for (int d = 0; d < NUM_DOMAINS; d++) begin
         if (mask[d]) begin
            r[d*DOMAIN_W +: DOMAIN_W] = new_v[d*DOMAIN_W +: DOMAIN_W];
         end
      end
      return r;
   endfunction

   // Post-write value seen by a full-width read port
   function automatic logic [DW-1:0] port_value(input logic [ADDR_W-1:0]   addr,
                                                input logic [DOMAIN_W-1:0] int_tap,
                                                input logic [DW-1:0]       rns_tap);
      logic [DW-1:0] r;
      if (addr[IW] == BANK_RNS) begin
         r = (rns_wr && (wr_addr == addr)) ? merge_lanes(rns_tap, wr_data, wr_mask) : rns_tap;
      end else begin
         r = DW'((int_wr && (wr_addr == addr)) ? wr_data[DOMAIN_W-1:0] : int_tap);
      end
      return r;
   endfunction

   // Clear engine next state: walk idx 0..DEPTH-1 then return to IDLE
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            if (idx_q == IW'(DEPTH - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Scoreboard: write clears, then reservation sets, clear engine wipes its entry
   always_comb begin
      busy_wc = busy_q;
      if (wr_go && (wr_mask != '0)) begin
         busy_wc[wr_addr] = 1'b0;
      end
      busy_d = busy_wc;
      if (rsv_en && !in_clear) begin
         busy_d[rsv_addr] = 1'b1;
      end
      if (in_clear) begin
         busy_d[{BANK_INT, idx_q}] = 1'b0;
         busy_d[{BANK_RNS, idx_q}] = 1'b0;
      end
   end

   // Read-port next values; reads during a clear return zero
   always_comb begin
      rd_data1_d  = '0;
      rd_data2_d  = '0;
      rd_data3_d  = '0;
      rd_hazard_d = '0;
      if (!in_clear) begin
         rd_data1_d  = port_value(rd_addr1, int_rd1_c, rns_rd1_c);
         rd_data2_d  = port_value(rd_addr2, int_rd2_c, rns_rd2_c);
         rd_data3_d  = (int_wr && (wr_addr[IW-1:0] == rd_addr3)) ? wr_data[DOMAIN_W-1:0] : int_rd3_c;
         rd_hazard_d = {busy_wc[rd_addr2], busy_wc[rd_addr1]};
      end
   end

   // Control state, scoreboard and busy flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         busy_q     <= '0;
         clr_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         clr_busy_q <= (state_d == CLEAR);
      end
   end

   // Read output registers, updated only on rd_en
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data1_q  <= '0;
         rd_data2_q  <= '0;
         rd_data3_q  <= '0;
         rd_hazard_q <= '0;
      end else if (rd_en) begin
         rd_data1_q  <= rd_data1_d;
         rd_data2_q  <= rd_data2_d;
         rd_data3_q  <= rd_data3_d;
         rd_hazard_q <= rd_hazard_d;
      end
   end

   assign rd_data1  = rd_data1_q;
   assign rd_data2  = rd_data2_q;
   assign rd_data3  = rd_data3_q;
   assign rd_hazard = rd_hazard_q;
   assign clr_busy  = clr_busy_q;

endmodule : rns_banked_reg_file
